mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one byte-wide memory port between two requesters (port 0: CPU
// instruction fetch, port 1: CPU load/store or debug loader). Each access is
// sequenced to the memory's timing: read data returns one cycle after
// memory_read_en is sampled (qualified by mem_ready), and a write completes in
// the single cycle memory_write_en is high. Each requester sees a uniform
// req/done handshake, with read data and a read-timeout error.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin on a tie (port 0 wins the first tie)
//                  undefined -> fixed priority, port 0 always wins a tie
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pX_req                    level request, held stable until pX_done
//   pX_we / pX_addr / pX_wdata  access type, address, write data
//   pX_rdata                  read data, valid while pX_done = 1
//   pX_done                   one-cycle completion pulse
//   pX_err                    qualifies pX_done: the read timed out
//   mem_addr / mem_data_in    memory address and write data
//   mem_data_out / mem_ready  memory read data and its valid flag
//   memory_read_en / memory_write_en  memory strobes (never both high)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  output logic              p0_err,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              p1_err,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              memory_read_en,
  output logic              memory_write_en,
  input  logic              mem_ready
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // The counter starts at 0 in the first RD_WAIT cycle, so reaching this
  // value without mem_ready means TIMEOUT_CYCLES wait cycles have elapsed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;   // 0 = port 0 owns the access, 1 = port 1

  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_d;
  logic              read_en_d, write_en_d;
  logic [DATA_W-1:0] p0_rdata_d, p1_rdata_d;
  logic              p0_done_d, p1_done_d;
  logic              p0_err_d, p1_err_d;

  logic win;      // port that would be granted if IDLE sees a request
  logic win_we;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
`endif

  // -------------------------------------------------------------------------
  // Arbitration: only meaningful in IDLE with at least one request.
  // -------------------------------------------------------------------------
  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On a tie the port that did not win last time goes first.
    if (p0_req && p1_req) win = ~last_grant_q;
    else                  win = ~p0_req;
`else
    win = ~p0_req;
`endif
    win_we = win ? p1_we : p0_we;
  end

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first (hold its current
    // value), so no path through the case leaves one unassigned and no latch
    // is inferred.
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    mem_addr_d    = mem_addr;
    mem_data_in_d = mem_data_in;
    read_en_d     = memory_read_en;
    write_en_d    = memory_write_en;
    p0_rdata_d    = p0_rdata;
    p1_rdata_d    = p1_rdata;
    p0_done_d     = p0_done;
    p1_done_d     = p1_done;
    p0_err_d      = p0_err;
    p1_err_d      = p1_err;
`ifdef MEM_ARB_RR_EN
    last_grant_d  = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          grant_d       = win;
          mem_addr_d    = win ? p1_addr  : p0_addr;
          mem_data_in_d = win ? p1_wdata : p0_wdata;
`ifdef MEM_ARB_RR_EN
          last_grant_d  = win;
`endif
          if (win_we) begin
            write_en_d = 1'b1;
            state_d    = WR_ISSUE;
          end else begin
            read_en_d  = 1'b1;
            state_d    = RD_ISSUE;
          end
        end
      end

      RD_ISSUE: begin
        // The read strobe lasts exactly one cycle; mem_ready is not looked at
        // here because the data cannot arrive before the strobe is sampled.
        read_en_d = 1'b0;
        cnt_d     = '0;
        state_d   = RD_WAIT;
      end

      RD_WAIT: begin
        if (mem_ready) begin
          if (grant_q) begin
            p1_rdata_d = mem_data_out;
            p1_done_d  = 1'b1;
            p1_err_d   = 1'b0;
          end else begin
            p0_rdata_d = mem_data_out;
            p0_done_d  = 1'b1;
            p0_err_d   = 1'b0;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: rdata keeps its previous value, err flags the failure.
          if (grant_q) begin
            p1_done_d = 1'b1;
            p1_err_d  = 1'b1;
          end else begin
            p0_done_d = 1'b1;
            p0_err_d  = 1'b1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WR_ISSUE: begin
        write_en_d = 1'b0;
        if (grant_q) begin
          p1_done_d = 1'b1;
          p1_err_d  = 1'b0;
        end else begin
          p0_done_d = 1'b1;
          p0_err_d  = 1'b0;
        end
        state_d = DONE;
      end

      DONE: begin
        // done (and its err qualifier) is a single-cycle pulse.
        p0_done_d = 1'b0;
        p1_done_d = 1'b0;
        p0_err_d  = 1'b0;
        p1_err_d  = 1'b0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      grant_q         <= 1'b0;
      mem_addr        <= '0;
      mem_data_in     <= '0;
      memory_read_en  <= 1'b0;
      memory_write_en <= 1'b0;
      p0_rdata        <= '0;
      p1_rdata        <= '0;
      p0_done         <= 1'b0;
      p1_done         <= 1'b0;
      p0_err          <= 1'b0;
      p1_err          <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q    <= 1'b1;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      grant_q         <= grant_d;
      mem_addr        <= mem_addr_d;
      mem_data_in     <= mem_data_in_d;
      memory_read_en  <= read_en_d;
      memory_write_en <= write_en_d;
      p0_rdata        <= p0_rdata_d;
      p1_rdata        <= p1_rdata_d;
      p0_done         <= p0_done_d;
      p1_done         <= p1_done_d;
      p0_err          <= p0_err_d;
      p1_err          <= p1_err_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q    <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A small behavioural memory answers
// reads one cycle after memory_read_en is sampled; its initial contents are
// mem[i] = i ^ 8'h39 (so mem[5] = 8'h3C). Inputs are driven and outputs are
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        p0_done, p0_err, p1_done, p1_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in, mem_data_out;
  logic        memory_read_en, memory_write_en, mem_ready;

  logic        mem_init;
  logic        ready_en;
  logic [7:0]  mem [0:255];

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  mem_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .p0_req          (p0_req),
    .p0_we           (p0_we),
    .p0_addr         (p0_addr),
    .p0_wdata        (p0_wdata),
    .p0_rdata        (p0_rdata),
    .p0_done         (p0_done),
    .p0_err          (p0_err),
    .p1_req          (p1_req),
    .p1_we           (p1_we),
    .p1_addr         (p1_addr),
    .p1_wdata        (p1_wdata),
    .p1_rdata        (p1_rdata),
    .p1_done         (p1_done),
    .p1_err          (p1_err),
    .mem_addr        (mem_addr),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out),
    .memory_read_en  (memory_read_en),
    .memory_write_en (memory_write_en),
    .mem_ready       (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: write at the edge that samples write_en, read data
  // and ready one cycle after the edge that samples read_en.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h39;
      mem_data_out <= 8'h00;
      mem_ready    <= 1'b0;
    end else begin
      if (memory_write_en) mem[mem_addr[7:0]] <= mem_data_in;
      if (memory_read_en)  mem_data_out <= mem[mem_addr[7:0]];
      mem_ready <= memory_read_en && ready_en;
    end
  end

  // Invariant monitor: strobes and done pulses are mutually exclusive.
  always @(negedge clk) begin
    if (memory_read_en && memory_write_en) viol++;
    if (p0_done && p1_done) viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete transaction on one port. Latency counts falling edges after
  // the one that raised req, so a read reports 3 and a write 2.
  task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                        input logic [7:0] wdata, output int lat, output int rd_cyc,
                        output int wr_cyc, output int other_done,
                        output logic [7:0] rdata, output logic err);
    bit seen;
    lat = -1; rd_cyc = 0; wr_cyc = 0; other_done = 0; rdata = 8'hxx; err = 1'bx;
    seen = 1'b0;
    @(negedge clk);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (memory_read_en)  rd_cyc++;
      if (memory_write_en) wr_cyc++;
      if (port ? p0_done : p1_done) other_done++;
      if (port ? p1_done : p0_done) begin
        lat   = n;
        rdata = port ? p1_rdata : p0_rdata;
        err   = port ? p1_err   : p0_err;
        seen  = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          lat, rd_c, wr_c, oth, n, cyc;
    logic [7:0]  rd;
    logic        er;
    int          order [4];
    logic [7:0]  data  [4];
    int          exp_order [4];
    logic [7:0]  exp_data  [4];
    int          d_cyc [2];
    logic [7:0]  d_dat [2];
    int          stray;

    // port, we, addr, wdata, rdata seen at done, err, latency, rd strobes, wr strobes
    vecs[0] = '{1'b0, 1'b0, 32'h05, 8'h00, 8'h3C, 1'b0, 3, 1, 0};
    vecs[1] = '{1'b1, 1'b1, 32'h08, 8'hA5, 8'h00, 1'b0, 2, 0, 1};
    vecs[2] = '{1'b1, 1'b0, 32'h08, 8'h00, 8'hA5, 1'b0, 3, 1, 0};
    vecs[3] = '{1'b0, 1'b1, 32'h20, 8'h77, 8'h3C, 1'b0, 2, 0, 1};
    vecs[4] = '{1'b0, 1'b0, 32'h20, 8'h00, 8'h77, 1'b0, 3, 1, 0};
    vecs[5] = '{1'b1, 1'b0, 32'hFF, 8'h00, 8'hC6, 1'b0, 3, 1, 0};
    vecs[6] = '{1'b1, 1'b1, 32'hFF, 8'h00, 8'hC6, 1'b0, 2, 0, 1};
    vecs[7] = '{1'b0, 1'b0, 32'hFF, 8'h00, 8'h00, 1'b0, 3, 1, 0};

    rst = 1'b1; mem_init = 1'b1; ready_en = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;

    // Reset state
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_data_in", {24'h0, mem_data_in}, 32'h0);
    check("rst_enables", {30'h0, memory_read_en, memory_write_en}, 32'h0);
    check("rst_p0", {22'h0, p0_rdata, p0_done, p0_err}, 32'h0);
    check("rst_p1", {22'h0, p1_rdata, p1_done, p1_err}, 32'h0);
    rst = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd_c, wr_c, oth, rd, er);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rdata", i), {24'h0, rd}, {24'h0, vecs[i].exp_rdata});
      check($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d_rd_strobes", i), rd_c, vecs[i].exp_rd);
      check($sformatf("v%0d_wr_strobes", i), wr_c, vecs[i].exp_wr);
      check($sformatf("v%0d_other_done", i), oth, 0);
    end

    // Simultaneous continuous reads, starting from reset (last_grant = 1)
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (p0_done) begin
        order[n] = 0; data[n] = p0_rdata; n++;
      end else if (p1_done) begin
        order[n] = 1; data[n] = p1_rdata; n++;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
    exp_data  = '{8'h39, 8'h38, 8'h39, 8'h38};
`else
    exp_order = '{0, 0, 0, 0};
    exp_data  = '{8'h39, 8'h39, 8'h39, 8'h39};
`endif
    check("tie_done_count", n, 4);
    check("tie_period", cyc, 15);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tie_order%0d", i), order[i], exp_order[i]);
      check($sformatf("tie_data%0d", i), {24'h0, data[i]}, {24'h0, exp_data[i]});
    end
    repeat (2) @(negedge clk);

    // Timeout: memory never answers; rdata keeps the last read (mem[0])
    ready_en = 1'b0;
    do_txn(1'b0, 1'b0, 32'h05, 8'h00, lat, rd_c, wr_c, oth, rd, er);
    check("to_latency", lat, 17);
    check("to_err", {31'h0, er}, 32'h1);
    check("to_rdata_held", {24'h0, rd}, 32'h39);
    ready_en = 1'b1;
    do_txn(1'b0, 1'b0, 32'h0A, 8'h00, lat, rd_c, wr_c, oth, rd, er);
    check("after_to_latency", lat, 3);
    check("after_to_err", {31'h0, er}, 32'h0);
    check("after_to_rdata", {24'h0, rd}, 32'h33);

    // Reset while in RD_WAIT
    @(negedge clk);
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; p1_req = 1'b0;
    @(negedge clk);
    check("midrst_enables", {30'h0, memory_read_en, memory_write_en}, 32'h0);
    check("midrst_p0", {22'h0, p0_rdata, p0_done, p0_err}, 32'h0);
    check("midrst_p1", {22'h0, p1_rdata, p1_done, p1_err}, 32'h0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (p0_done || p1_done) stray++;
    end
    check("midrst_no_done", stray, 0);
    do_txn(1'b1, 1'b1, 32'h02, 8'h11, lat, rd_c, wr_c, oth, rd, er);
    check("post_rst_wr_latency", lat, 2);
    do_txn(1'b1, 1'b0, 32'h02, 8'h00, lat, rd_c, wr_c, oth, rd, er);
    check("post_rst_rd_data", {24'h0, rd}, 32'h11);

    // Back-to-back reads on port 0, address updated on done
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0A;
    n = 0; cyc = 0;
    d_cyc = '{-1, -1};
    d_dat = '{8'h00, 8'h00};
    while (n < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (p0_done) begin
        d_cyc[n] = cyc; d_dat[n] = p0_rdata; n++;
        if (n == 1) p0_addr = 32'h0B;
        else        p0_req  = 1'b0;
      end
    end
    p0_req = 1'b0;
    check("b2b_first_cycle", d_cyc[0], 3);
    check("b2b_second_cycle", d_cyc[1], 7);
    check("b2b_data0", {24'h0, d_dat[0]}, 32'h33);
    check("b2b_data1", {24'h0, d_dat[1]}, 32'h32);
    repeat (2) @(negedge clk);

    check("invariants", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
